// File: rtl/mul_16bitx16_booth_pp.sv
// Two-stage radix-4 Booth partial-product generator for signed W x W multiply.
// Emits PP_NUM sign-extended rows transposed column-major for the Wallace compressors.
module mul_16bitx16_booth_pp #(
  parameter  int W      = 16,
  localparam int PP_NUM = W / 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [W-1:0]             i_num_a,
  input  logic [W-1:0]             i_num_b,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2*W*PP_NUM-1:0]    o_pp
);

  localparam int RW = 2 * W;

  logic                     s1_vld_q, s1_vld_d;
  logic [W-1:0]             a_q, a_d;
  logic [3*PP_NUM-1:0]      code_q, code_d;
  logic                     o_valid_q, o_valid_d;
  logic [RW*PP_NUM-1:0]     pp_q, pp_d;

  logic                     s2_adv, s1_adv, accept;
  logic [W:0]               b_ext;
  logic [RW-1:0]            a_ext;
  logic [RW-1:0]            mult;
  logic [RW-1:0]            row [PP_NUM];

  // A stage moves when the one after it is empty or draining this cycle.
  assign s2_adv  = !o_valid_q || i_ready;
  assign s1_adv  = !s1_vld_q || s2_adv;
  assign accept  = i_valid && s1_adv;
  assign o_ready = s1_adv;
  assign o_valid = o_valid_q;
  assign o_pp    = pp_q;

  // Stage 1: capture A and the Booth triplets of B (b[-1] is the appended zero).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    a_d      = a_q;
    code_d   = code_q;
    b_ext    = {i_num_b, 1'b0};
    s1_vld_d = s1_adv ? i_valid : s1_vld_q;
    if (accept) begin
      a_d = i_num_a;
      for (int i = 0; i < PP_NUM; i++) begin
        code_d[3*i +: 3] = b_ext[2*i +: 3];
      end
    end
  end

  // Stage 2: A is sign-extended to 2W first, so -A and -2A stay exact for A = -2^(W-1).
  always_comb begin
    a_ext     = {{W{a_q[W-1]}}, a_q};
    mult      = '0;
    pp_d      = pp_q;
    o_valid_d = o_valid_q;
    for (int i = 0; i < PP_NUM; i++) begin
      case (code_q[3*i +: 3])
        3'b001, 3'b010: mult = a_ext;
        3'b011:         mult = a_ext << 1;
        3'b100:         mult = -(a_ext << 1);
        3'b101, 3'b110: mult = -a_ext;
        default:        mult = '0;
      endcase
      row[i] = mult << (2 * i);
    end
    if (s2_adv) begin
      o_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        for (int k = 0; k < RW; k++) begin
          for (int r = 0; r < PP_NUM; r++) begin
            pp_d[PP_NUM*k + r] = row[r][k];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: data registers are reset too, so o_pp reads zero whenever reset has just been applied.
      s1_vld_q  <= 1'b0;
      a_q       <= '0;
      code_q    <= '0;
      o_valid_q <= 1'b0;
      pp_q      <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      s1_vld_q  <= s1_vld_d;
      a_q       <= a_d;
      code_q    <= code_d;
      o_valid_q <= o_valid_d;
      pp_q      <= pp_d;
    end
  end

endmodule

// File: tb/tb_mul_16bitx16_booth_pp.sv
// Self-checking bench for mul_16bitx16_booth_pp: directed vectors, pipeline corners,
// and random traffic scored against an arithmetic Booth-digit model.
module tb_mul_16bitx16_booth_pp;

  logic         clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [15:0]  i_num_a;
  logic [15:0]  i_num_b;
  logic         o_valid;
  logic         i_ready;
  logic [255:0] o_pp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_sum;
    logic [31:0] exp_row0;
    logic [31:0] exp_row1;
    logic [31:0] exp_row7;
    logic        all_zero;
  } vec_t;

  pair_t sb[$];

  mul_16bitx16_booth_pp dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_pp    (o_pp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Radix-4 Booth digit d_i = -2*b[2i+1] + b[2i] + b[2i-1]; row_i = d_i * A * 4^i mod 2^32.
  function automatic logic [31:0] model_row(input logic [15:0] a, input logic [15:0] b, input int i);
    logic [16:0] bx;
    int          digit;
    longint      p;
    bx    = {b, 1'b0};
    digit = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
    p     = longint'(digit) * longint'($signed(a));
    p     = p * (longint'(1) << (2 * i));
    return p[31:0];
  endfunction

  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic [31:0] get_row(input logic [255:0] pp, input int r);
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = pp[8*k + r];
    return v;
  endfunction

  function automatic logic [31:0] get_sum(input logic [255:0] pp);
    logic [31:0] s;
    s = '0;
    for (int r = 0; r < 8; r++) s = s + get_row(pp, r);
    return s;
  endfunction

  // Scoreboard: handshakes are observed on the falling edge, before the rising edge that completes them.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          pair_t e;
          e = sb.pop_front();
          n_pop++;
          for (int r = 0; r < 8; r++)
            check($sformatf("sb_row%0d a=%0h b=%0h", r, e.a, e.b),
                  64'(get_row(o_pp, r)), 64'(model_row(e.a, e.b, r)));
          check($sformatf("sb_sum a=%0h b=%0h", e.a, e.b),
                64'(get_sum(o_pp)), 64'(model_prod(e.a, e.b)));
        end
      end
      if (i_valid && o_ready) sb.push_back('{a: i_num_a, b: i_num_b});
    end
  end

  always @(posedge i_rst) sb.delete();

  // Present one pair into an empty pipeline with i_ready=1; returns at the
  // falling edge after the second rising edge, when the result should be valid.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    i_valid = 1'b1;
    i_num_a = a;
    i_num_b = b;
    @(negedge clk);
    check("lat_ready", 64'(o_ready), 64'(1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_after_accept_edge", 64'(o_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("lat_after_second_edge", 64'(o_valid), 64'(1));
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  vec_t        vec[6];
  logic [7:0]  vseq;
  logic [255:0] snap;
  logic        snap_taken;
  logic        acc;
  int          idx;
  int          pop_base;
  int          sent;
  logic [15:0] bp_a[3];
  logic [15:0] bp_b[3];
  logic [15:0] corner[4];

  initial begin
    vec[0] = '{16'd5,     16'd3,     32'h0000_000F, 32'hFFFF_FFFB, 32'h0000_0014, 32'h0,         1'b0};
    vec[1] = '{16'h8000,  16'h8000,  32'h4000_0000, 32'h0,         32'h0,         32'h4000_0000, 1'b0};
    vec[2] = '{16'h7FFF,  16'h8000,  32'hC000_8000, 32'h0,         32'h0,         32'hC000_8000, 1'b0};
    vec[3] = '{16'hFFFF,  16'hFFFF,  32'h0000_0001, 32'h0000_0001, 32'h0,         32'h0,         1'b0};
    vec[4] = '{16'h1234,  16'h0000,  32'h0,         32'h0,         32'h0,         32'h0,         1'b1};
    vec[5] = '{16'd3,     16'd2,     32'h0000_0006, 32'hFFFF_FFFA, 32'h0000_000C, 32'h0,         1'b0};
    bp_a   = '{16'h0101, 16'hF00D, 16'h8000};
    bp_b   = '{16'h7FFF, 16'h0003, 16'hFFFF};
    corner = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_num_a = '0;
    i_num_b = '0;
    #12;
    check("reset_o_valid", 64'(o_valid), 64'(0));
    check("reset_o_pp_zero", 64'(o_pp == '0), 64'(1));
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_o_ready", 64'(o_ready), 64'(1));
    check("post_reset_o_valid", 64'(o_valid), 64'(0));

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      launch(vec[i].a, vec[i].b);
      check($sformatf("vec%0d_sum", i),  64'(get_sum(o_pp)),   64'(vec[i].exp_sum));
      check($sformatf("vec%0d_row0", i), 64'(get_row(o_pp, 0)), 64'(vec[i].exp_row0));
      check($sformatf("vec%0d_row1", i), 64'(get_row(o_pp, 1)), 64'(vec[i].exp_row1));
      check($sformatf("vec%0d_row7", i), 64'(get_row(o_pp, 7)), 64'(vec[i].exp_row7));
      check($sformatf("vec%0d_all_zero", i), 64'(o_pp == '0), 64'(vec[i].all_zero));
      if (i == 0) begin
        check("vec0_col0", 64'(o_pp[7:0]),   64'(8'h01));
        check("vec0_col2", 64'(o_pp[23:16]), 64'(8'h02));
      end
      @(posedge clk); #1;
    end
    drain();

    // Back-to-back: four pairs driven after edges 0..3, accepted at 1..4, valid after 2..5.
    vseq = '0;
    for (int c = 0; c < 8; c++) begin
      i_valid = (c < 4);
      i_num_a = 16'(16'h1111 * (c + 1));
      i_num_b = 16'(16'hF0F0 - c);
      @(negedge clk);
      vseq[c] = o_valid;
      @(posedge clk); #1;
    end
    check("b2b_valid_pattern", 64'(vseq), 64'(8'b0011_1100));
    drain();

    // Back-pressure: i_ready low for 5 cycles with 3 pairs offered.
    i_ready    = 1'b0;
    idx        = 0;
    snap_taken = 1'b0;
    snap       = '0;
    pop_base   = n_pop;
    for (int c = 0; c < 5; c++) begin
      i_valid = (idx < 3);
      i_num_a = bp_a[idx < 3 ? idx : 2];
      i_num_b = bp_b[idx < 3 ? idx : 2];
      @(negedge clk);
      if (i_valid && o_ready) idx++;
      if (o_valid && !snap_taken) begin
        snap       = o_pp;
        snap_taken = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", 64'(idx), 64'(2));
    check("bp_o_ready_low", 64'(o_ready), 64'(0));
    check("bp_o_valid_held", 64'(o_valid), 64'(1));
    check("bp_o_pp_stable", 64'(o_pp == snap), 64'(1));
    i_ready = 1'b1;
    acc     = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      i_valid = 1'b1;
      i_num_a = bp_a[2];
      i_num_b = bp_b[2];
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
    end
    check("bp_third_accepted", 64'(acc), 64'(1));
    drain();
    check("bp_results_out", 64'(n_pop - pop_base), 64'(3));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Reset while both stages hold data.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_num_a = 16'd100;
    i_num_b = 16'd7;
    @(posedge clk); #1;
    i_num_a = 16'hFF38;
    i_num_b = 16'hFFF7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("pre_rst_o_valid", 64'(o_valid), 64'(1));
    check("pre_rst_s1_full", 64'(o_ready), 64'(0));
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_o_valid", 64'(o_valid), 64'(0));
    check("mid_rst_o_pp_zero", 64'(o_pp == '0), 64'(1));
    check("mid_rst_o_ready", 64'(o_ready), 64'(1));
    @(posedge clk); #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    launch(16'h0011, 16'h0022);
    check("post_rst_sum", 64'(get_sum(o_pp)), 64'(32'h0000_0242));
    @(posedge clk); #1;
    drain();

    // Random traffic with random valid/ready; inputs held until accepted.
    sent    = 0;
    acc     = 1'b0;
    i_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      if (!i_valid || acc) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_num_a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
        i_num_b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      end
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = i_valid && o_ready;
      if (acc) sent++;
      @(posedge clk); #1;
    end
    drain();
    check("rand_sent", 64'(sent), 64'(10000));
    check("rand_sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
